// File: rtl/game_pkg.sv
// Shared player-state encoding and collision-vector bit positions.
// Types and constants only: no latency, no backpressure.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WALK = 3'd1,
    ST_JUMP = 3'd2,
    ST_FALL = 3'd3,
    ST_DEAD = 3'd4
  } pstate_t;

  localparam int COL_GROUND = 0;
  localparam int COL_CEIL   = 1;
  localparam int COL_WALL_L = 2;
  localparam int COL_WALL_R = 3;

endpackage

// File: rtl/sat_add.sv
// Signed a+b clamped to [lo, hi], result truncated to OW bits.
// Combinational, zero latency; no backpressure.
module sat_add #(
  parameter int W  = 16,
  parameter int OW = 16
) (
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [W-1:0]  lo,
  input  logic signed [W-1:0]  hi,
  output logic        [OW-1:0] sum
);

  logic signed [W:0] raw;

  // One guard bit so the raw sum never wraps before the clamp.
  always_comb begin
    raw = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (raw < $signed({lo[W-1], lo})) begin
      sum = lo[OW-1:0];
    end else if (raw > $signed({hi[W-1], hi})) begin
      sum = hi[OW-1:0];
    end else begin
      sum = raw[OW-1:0];
    end
  end

endmodule

// File: rtl/player_move.sv
// Per-frame player physics: walk, jump, gravity, collisions, death/respawn.
// Updates 1 cycle after an accepted frame_tick (upd_done pulses then); no backpressure.
module player_move
  import game_pkg::*;
#(
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int V_W       = 6,
  parameter int WALK_STEP = 1,
  parameter int JUMP_V    = 14,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 14,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 623,
  parameter int Y_MAX     = 463,
  parameter int SPAWN_X   = 16,
  parameter int SPAWN_Y   = 400
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           jump,
  input  logic           respawn,
  input  logic [3:0]     collision,
  input  logic           hazard,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic [2:0]     state,
  output logic           facing,
  output logic           dead,
  output logic           upd_done
);

  localparam int AW = (X_W + 2 > V_W + Y_W + 1) ? X_W + 2 : V_W + Y_W + 1;
  typedef logic signed [AW-1:0] sw_t;

  logic [X_W-1:0]        x_q, x_nx, x_sum;
  logic [Y_W-1:0]        y_q, y_nx, y_sum;
  logic signed [V_W-1:0] vy, vy_nx;
  pstate_t               state_q, state_nx;
  logic                  facing_q, facing_nx;
  logic                  dead_q, dead_nx;
  logic                  upd_q, tick_q, jump_q, jump_lat;

  logic accept, jump_evt, ground, ceil, grounded, floor_hit, ceil_hit;
  sw_t  x_ext, y_ext, vy_ext, step, vy_grav, vy_c, vy_fin;

  assign accept   = frame_tick & ~tick_q;
  assign jump_evt = jump_lat | (jump & ~jump_q);
  assign ground   = collision[COL_GROUND];
  assign ceil     = collision[COL_CEIL];

  assign x_ext  = {{(AW-X_W){1'b0}}, x_q};
  assign y_ext  = {{(AW-Y_W){1'b0}}, y_q};
  assign vy_ext = {{(AW-V_W){vy[V_W-1]}}, vy};

  // Walls cancel motion toward them; facing still follows a single key.
  always_comb begin
    step = '0;
    if (move_left && !move_right && !collision[COL_WALL_L]) begin
      step = -sw_t'(WALK_STEP);
    end else if (move_right && !move_left && !collision[COL_WALL_R]) begin
      step = sw_t'(WALK_STEP);
    end
  end

  sat_add #(.W(AW), .OW(X_W)) u_x (
    .a   (x_ext),
    .b   (step),
    .lo  (sw_t'(X_MIN)),
    .hi  (sw_t'(X_MAX)),
    .sum (x_sum)
  );

  sat_add #(.W(AW), .OW(AW)) u_vy (
    .a   (vy_ext),
    .b   (sw_t'(GRAVITY)),
    .lo  (sw_t'(-(2 ** (V_W - 1)))),
    .hi  (sw_t'(MAX_FALL)),
    .sum (vy_grav)
  );

  always_comb begin
    if (jump_evt && ground) begin
      vy_c = -sw_t'(JUMP_V);
    end else if (ground && !vy[V_W-1]) begin
      vy_c = '0;
    end else begin
      vy_c = vy_grav;
    end
    if (ceil && vy_c < 0) begin
      vy_c = '0;
    end
  end

  sat_add #(.W(AW), .OW(Y_W)) u_y (
    .a   (y_ext),
    .b   (vy_c),
    .lo  ('0),
    .hi  (sw_t'(Y_MAX)),
    .sum (y_sum)
  );

  // Clamping at the floor lands the player; clamping at the top is a ceiling.
  always_comb begin
    floor_hit = (y_sum == Y_W'(Y_MAX)) && !vy_c[AW-1];
    ceil_hit  = (y_sum == '0) && vy_c[AW-1];
    vy_fin    = (floor_hit || ceil_hit) ? '0 : vy_c;
    grounded  = (ground && !vy_c[AW-1]) || floor_hit;
  end

  always_comb begin
    x_nx      = x_q;
    y_nx      = y_q;
    vy_nx     = vy;
    state_nx  = state_q;
    facing_nx = facing_q;
    dead_nx   = dead_q;
    if (accept) begin
      if (state_q == ST_DEAD) begin
        if (respawn) begin
          x_nx     = X_W'(SPAWN_X);
          y_nx     = Y_W'(SPAWN_Y);
          vy_nx    = '0;
          state_nx = ST_IDLE;
          dead_nx  = 1'b0;
        end
      end else if (hazard) begin
        state_nx = ST_DEAD;
        dead_nx  = 1'b1;
      end else begin
        x_nx  = x_sum;
        y_nx  = y_sum;
        vy_nx = vy_fin[V_W-1:0];
        if (move_left ^ move_right) begin
          facing_nx = move_left;
        end
        if (vy_fin < 0) begin
          state_nx = ST_JUMP;
        end else if (vy_fin > 0 || !grounded) begin
          state_nx = ST_FALL;
        end else if (step != '0) begin
          state_nx = ST_WALK;
        end else begin
          state_nx = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= X_W'(SPAWN_X);
      y_q      <= Y_W'(SPAWN_Y);
      vy       <= '0;
      state_q  <= ST_IDLE;
      facing_q <= 1'b0;
      dead_q   <= 1'b0;
      upd_q    <= 1'b0;
      tick_q   <= 1'b0;
      jump_q   <= 1'b0;
      jump_lat <= 1'b0;
    end else begin
      x_q      <= x_nx;
      y_q      <= y_nx;
      vy       <= vy_nx;
      state_q  <= state_nx;
      facing_q <= facing_nx;
      dead_q   <= dead_nx;
      upd_q    <= accept;
      tick_q   <= frame_tick;
      jump_q   <= jump;
      // A press between ticks is held until the next tick consumes it.
      if (accept) begin
        jump_lat <= 1'b0;
      end else if (jump && !jump_q) begin
        jump_lat <= 1'b1;
      end
    end
  end

  assign x_pos    = x_q;
  assign y_pos    = y_q;
  assign state    = state_q;
  assign facing   = facing_q;
  assign dead     = dead_q;
  assign upd_done = upd_q;

endmodule
